// File: rtl/thermal_burst_reader_if.sv
// Request, data-stream and i2c_controller signals of the thermal burst reader.
// master = the reader itself, slave = the environment (requester + controller).
interface thermal_burst_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_reg_addr;
    logic [6:0]  req_len;

    logic        data_valid;
    logic [7:0]  data_byte;
    logic        data_last;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    logic [7:0]  i2c_address;
    logic        i2c_write_mode;
    logic [7:0]  i2c_transmit_data;
    logic        i2c_write_pending;
    logic        i2c_read_pending;
    logic        i2c_start_transfer;
    logic        i2c_busy;
    logic        i2c_byte_done;
    logic        i2c_nack;
    logic [7:0]  i2c_received_data;

    modport master (
        input  req_valid, req_reg_addr, req_len,
        input  i2c_busy, i2c_byte_done, i2c_nack, i2c_received_data,
        output req_ready, data_valid, data_byte, data_last, done, error, err_code,
        output i2c_address, i2c_write_mode, i2c_transmit_data,
        output i2c_write_pending, i2c_read_pending, i2c_start_transfer
    );

    modport slave (
        output req_valid, req_reg_addr, req_len,
        output i2c_busy, i2c_byte_done, i2c_nack, i2c_received_data,
        input  req_ready, data_valid, data_byte, data_last, done, error, err_code,
        input  i2c_address, i2c_write_mode, i2c_transmit_data,
        input  i2c_write_pending, i2c_read_pending, i2c_start_transfer
    );
endinterface

// File: rtl/thermal_burst_reader.sv
// Sequences i2c_controller through pointer write, repeated START and a sequential
// read of a thermal-sensor register burst, streaming bytes out as they arrive.
module thermal_burst_reader #(
    parameter logic [7:0]  DEV_ADDR       = 8'h52,
    parameter int          MAX_BURST      = 64,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    thermal_burst_reader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, WR_START, WR_HI, WR_LO, RD_START, READ, STOP_WAIT, ERR_WAIT
    } state_t;

    localparam logic [6:0] MAX_LEN = 7'(MAX_BURST);

    state_t      state, state_n;
    logic [15:0] addr_q, addr_n;
    logic [6:0]  remaining, remaining_n;
    logic [15:0] tmo_cnt, tmo_cnt_n;
    logic        data_valid_q, data_valid_n;
    logic [7:0]  data_byte_q, data_byte_n;
    logic        data_last_q, data_last_n;
    logic        done_q, done_n;
    logic        error_q, error_n;
    logic [1:0]  err_code_q, err_code_n;
    logic        accept, len_bad, progress;

    assign accept  = bus.req_valid && (state == IDLE);
    assign len_bad = (bus.req_len == 7'd0) || (bus.req_len > MAX_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr_q       <= '0;
            remaining    <= '0;
            tmo_cnt      <= '0;
            data_valid_q <= 1'b0;
            data_byte_q  <= '0;
            data_last_q  <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state        <= state_n;
            addr_q       <= addr_n;
            remaining    <= remaining_n;
            tmo_cnt      <= tmo_cnt_n;
            data_valid_q <= data_valid_n;
            data_byte_q  <= data_byte_n;
            data_last_q  <= data_last_n;
            done_q       <= done_n;
            error_q      <= error_n;
            err_code_q   <= err_code_n;
        end
    end

    always_comb begin
        state_n      = state;
        addr_n       = addr_q;
        remaining_n  = remaining;
        data_valid_n = 1'b0;
        data_byte_n  = data_byte_q;
        data_last_n  = 1'b0;
        done_n       = 1'b0;
        error_n      = 1'b0;
        err_code_n   = err_code_q;
        progress     = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (len_bad) begin
                        err_code_n = 2'd1;
                        error_n    = 1'b1;
                    end else begin
                        err_code_n  = 2'd0;
                        addr_n      = bus.req_reg_addr;
                        remaining_n = bus.req_len;
                        state_n     = WR_START;
                    end
                end
            end
            WR_START: state_n = WR_HI;
            WR_HI: begin
                if (bus.i2c_byte_done) begin
                    progress = 1'b1;
                    if (bus.i2c_nack) begin
                        err_code_n = 2'd2;
                        state_n    = ERR_WAIT;
                    end else begin
                        state_n = WR_LO;
                    end
                end
            end
            WR_LO: begin
                if (bus.i2c_byte_done) begin
                    progress = 1'b1;
                    if (bus.i2c_nack) begin
                        err_code_n = 2'd2;
                        state_n    = ERR_WAIT;
                    end else begin
                        state_n = RD_START;
                    end
                end
            end
            RD_START: state_n = READ;
            READ: begin
                if (bus.i2c_byte_done) begin
                    progress     = 1'b1;
                    data_valid_n = 1'b1;
                    data_byte_n  = bus.i2c_received_data;
                    remaining_n  = remaining - 7'd1;
                    if (remaining <= 7'd1) begin
                        data_last_n = 1'b1;
                        state_n     = STOP_WAIT;
                    end
                end
            end
            STOP_WAIT: begin
                if (!bus.i2c_busy) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            ERR_WAIT: begin
                if (!bus.i2c_busy) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A stalled controller is abandoned without waiting for busy to drop.
        if (state != IDLE && state_n == state && !progress &&
            tmo_cnt == TIMEOUT_CYCLES - 16'd1) begin
            state_n    = IDLE;
            error_n    = 1'b1;
            err_code_n = 2'd3;
        end

        if (state == IDLE || state_n != state || progress)
            tmo_cnt_n = '0;
        else
            tmo_cnt_n = tmo_cnt + 16'd1;
    end

    // Controller-facing signals decode directly from the current state.
    assign bus.req_ready          = (state == IDLE);
    assign bus.i2c_address        = DEV_ADDR;
    assign bus.i2c_start_transfer = (state == WR_START) || (state == RD_START);
    assign bus.i2c_write_mode     = (state == WR_START) || (state == WR_HI) || (state == WR_LO);
    assign bus.i2c_write_pending  = (state == WR_START) || (state == WR_HI);
    assign bus.i2c_transmit_data  = (state == WR_START || state == WR_HI) ? addr_q[15:8] :
                                    (state == WR_LO) ? addr_q[7:0] : 8'h00;
    assign bus.i2c_read_pending   = ((state == RD_START) || (state == READ)) && (remaining > 7'd1);

    assign bus.data_valid = data_valid_q;
    assign bus.data_byte  = data_byte_q;
    assign bus.data_last  = data_last_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_thermal_burst_reader.sv
// Directed bench for thermal_burst_reader; the bench plays requester and i2c_controller.
module tb_thermal_burst_reader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    thermal_burst_reader_if bus();

    thermal_burst_reader #(
        .DEV_ADDR(8'h52), .MAX_BURST(64), .TIMEOUT_CYCLES(16'd100)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int n_start = 0, n_dv = 0, n_done = 0, n_err = 0, n_both = 0;
    int b_start, b_dv, b_done, b_err;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.i2c_start_transfer) n_start++;
            if (bus.data_valid) n_dv++;
            if (bus.done) n_done++;
            if (bus.error) n_err++;
            if (bus.done && bus.error) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic base();
        b_start = n_start; b_dv = n_dv; b_done = n_done; b_err = n_err;
    endtask

    task automatic deltas(input string tag, input int s, input int dv, input int d, input int e);
        chk({tag, "_starts"}, n_start - b_start, s);
        chk({tag, "_dvs"}, n_dv - b_dv, dv);
        chk({tag, "_dones"}, n_done - b_done, d);
        chk({tag, "_errors"}, n_err - b_err, e);
    endtask

    task automatic send_req(input logic [15:0] a, input logic [6:0] l);
        bus.req_valid = 1'b1; bus.req_reg_addr = a; bus.req_len = l;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wr_byte(input logic nack);
        bus.i2c_byte_done = 1'b1; bus.i2c_nack = nack;
        @(negedge clk);
        bus.i2c_byte_done = 1'b0; bus.i2c_nack = 1'b0;
    endtask

    task automatic rd_byte(input logic [7:0] d, input logic last, input logic rp, input string tag);
        chk({tag, "_rpend"}, bus.i2c_read_pending, rp);
        bus.i2c_byte_done = 1'b1; bus.i2c_received_data = d;
        @(negedge clk);
        bus.i2c_byte_done = 1'b0;
        chk({tag, "_dv"}, bus.data_valid, 1);
        chk({tag, "_byte"}, bus.data_byte, d);
        chk({tag, "_last"}, bus.data_last, last);
        @(negedge clk);
        chk({tag, "_dv_off"}, bus.data_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_reg_addr = '0; bus.req_len = '0;
        bus.i2c_busy = 1'b0; bus.i2c_byte_done = 1'b0; bus.i2c_nack = 1'b0;
        bus.i2c_received_data = '0;
        cyc(3);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_addr", bus.i2c_address, 8'h52);
        chk("rst_start", bus.i2c_start_transfer, 0);
        chk("rst_wmode", bus.i2c_write_mode, 0);
        chk("rst_dv", bus.data_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_code", bus.err_code, 0);
        reset = 1'b0;
        cyc(1);

        // 1: four-byte burst from 0x2400
        base();
        send_req(16'h2400, 7'd4);
        chk("t1_ready_low", bus.req_ready, 0);
        chk("t1_start", bus.i2c_start_transfer, 1);
        chk("t1_wmode", bus.i2c_write_mode, 1);
        chk("t1_tx_hi", bus.i2c_transmit_data, 8'h24);
        chk("t1_wpend", bus.i2c_write_pending, 1);
        bus.i2c_busy = 1'b1;
        cyc(1);
        chk("t1_start_once", bus.i2c_start_transfer, 0);
        wr_byte(1'b0);
        chk("t1_tx_lo", bus.i2c_transmit_data, 8'h00);
        chk("t1_wpend_lo", bus.i2c_write_pending, 0);
        wr_byte(1'b0);
        chk("t1_rstart", bus.i2c_start_transfer, 1);
        chk("t1_rmode", bus.i2c_write_mode, 0);
        chk("t1_rpend0", bus.i2c_read_pending, 1);
        cyc(1);
        rd_byte(8'hAA, 1'b0, 1'b1, "t1_b0");
        rd_byte(8'hBB, 1'b0, 1'b1, "t1_b1");
        rd_byte(8'hCC, 1'b0, 1'b1, "t1_b2");
        rd_byte(8'hDD, 1'b1, 1'b0, "t1_b3");
        chk("t1_done_wait_busy", bus.done, 0);
        bus.i2c_busy = 1'b0;
        cyc(1);
        chk("t1_done", bus.done, 1);
        chk("t1_ready_back", bus.req_ready, 1);
        cyc(1);
        chk("t1_done_pulse", bus.done, 0);
        cyc(1);
        deltas("t1", 2, 4, 1, 0);

        // 2: single-byte burst
        base();
        send_req(16'h1234, 7'd1);
        chk("t2_tx_hi", bus.i2c_transmit_data, 8'h12);
        bus.i2c_busy = 1'b1;
        cyc(1);
        wr_byte(1'b0);
        chk("t2_tx_lo", bus.i2c_transmit_data, 8'h34);
        wr_byte(1'b0);
        chk("t2_rstart", bus.i2c_start_transfer, 1);
        chk("t2_rpend_rstart", bus.i2c_read_pending, 0);
        cyc(1);
        rd_byte(8'h5A, 1'b1, 1'b0, "t2_b0");
        bus.i2c_busy = 1'b0;
        cyc(1);
        chk("t2_done", bus.done, 1);
        cyc(2);
        deltas("t2", 2, 1, 1, 0);

        // 3: rejected lengths
        base();
        send_req(16'h0000, 7'd0);
        chk("t3_len0_error", bus.error, 1);
        chk("t3_len0_code", bus.err_code, 1);
        chk("t3_len0_ready", bus.req_ready, 1);
        cyc(1);
        chk("t3_error_pulse", bus.error, 0);
        send_req(16'h0010, 7'd65);
        chk("t3_len65_error", bus.error, 1);
        chk("t3_len65_code", bus.err_code, 1);
        cyc(3);
        chk("t3_no_start_now", bus.i2c_start_transfer, 0);
        deltas("t3", 0, 0, 0, 2);

        // 4: NACK on register LSB
        base();
        send_req(16'h3300, 7'd2);
        bus.i2c_busy = 1'b1;
        cyc(1);
        wr_byte(1'b0);
        wr_byte(1'b1);
        chk("t4_code_latched", bus.err_code, 2);
        chk("t4_wpend_off", bus.i2c_write_pending, 0);
        chk("t4_rpend_off", bus.i2c_read_pending, 0);
        cyc(3);
        chk("t4_no_rstart", bus.i2c_start_transfer, 0);
        chk("t4_wait_busy", bus.error, 0);
        bus.i2c_busy = 1'b0;
        cyc(1);
        chk("t4_error", bus.error, 1);
        chk("t4_code", bus.err_code, 2);
        chk("t4_ready", bus.req_ready, 1);
        cyc(2);
        deltas("t4", 1, 0, 0, 1);

        // 5: controller stall after the high pointer byte, then recovery
        base();
        send_req(16'h0800, 7'd2);
        bus.i2c_busy = 1'b1;
        cyc(1);
        wr_byte(1'b0);
        k = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk);
            if (bus.error) begin
                k = i;
                break;
            end
        end
        chk("t5_tmo_cycle", k, 100);
        chk("t5_code", bus.err_code, 3);
        chk("t5_ready_busy_high", bus.req_ready, 1);
        bus.i2c_busy = 1'b0;
        cyc(1);
        send_req(16'h0102, 7'd2);
        chk("t5_code_cleared", bus.err_code, 0);
        bus.i2c_busy = 1'b1;
        cyc(1);
        wr_byte(1'b0);
        wr_byte(1'b0);
        cyc(1);
        rd_byte(8'h11, 1'b0, 1'b1, "t5_b0");
        rd_byte(8'h22, 1'b1, 1'b0, "t5_b1");
        bus.i2c_busy = 1'b0;
        cyc(1);
        chk("t5_done", bus.done, 1);
        cyc(2);
        deltas("t5", 3, 2, 1, 1);

        // 6: maximum length accepted, then reset mid-burst
        base();
        send_req(16'h4000, 7'd64);
        chk("t6_len64_no_error", bus.error, 0);
        chk("t6_len64_accepted", bus.req_ready, 0);
        bus.i2c_busy = 1'b1;
        cyc(1);
        wr_byte(1'b0);
        wr_byte(1'b0);
        cyc(1);
        rd_byte(8'h01, 1'b0, 1'b1, "t6_b0");
        rd_byte(8'h02, 1'b0, 1'b1, "t6_b1");
        reset = 1'b1;
        cyc(1);
        chk("t6_ready", bus.req_ready, 1);
        chk("t6_rpend", bus.i2c_read_pending, 0);
        chk("t6_wmode", bus.i2c_write_mode, 0);
        chk("t6_start", bus.i2c_start_transfer, 0);
        chk("t6_addr", bus.i2c_address, 8'h52);
        chk("t6_done", bus.done, 0);
        chk("t6_error", bus.error, 0);
        reset = 1'b0;
        bus.i2c_busy = 1'b0;
        cyc(3);
        chk("t6_idle", bus.req_ready, 1);
        deltas("t6", 2, 2, 0, 0);

        chk("no_done_error_overlap", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
